rr_ring_arbiter: RTL and testbench

RR_RING_ARBITER -- requirements
Module: rr_ring_arbiter

---
 rtl/rr_ring_arbiter.sv | 96 +++++++++
 tb/tb_rr_ring_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a one-hot ring pointer and a per-grant hold limit.
// A grant is released when its request drops or after MAX_HOLD cycles (preempt).
module rr_ring_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic [N-1:0] ptr,
  output logic         busy,
  output logic         preempt
);

  localparam int unsigned CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e        state_q;
  logic [N-1:0]  grant_q;
  logic [N-1:0]  ptr_q;
  logic [CW-1:0] cnt_q;
  logic          preempt_q;

  logic [N-1:0]  sel_d;
  logic [N-1:0]  ptr_d;
  logic          held;
  logic          found;
  int unsigned   ptr_idx;
  int unsigned   idx;

  // First set request scanning upward from the pointer position, with wrap.
  always_comb begin
    ptr_idx = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (ptr_q[i]) ptr_idx = i;
    end
    sel_d = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (ptr_idx + k) % N;
      if (!found && req[idx]) begin
        sel_d[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign held  = |(grant_q & req);
  assign ptr_d = {grant_q[N-2:0], grant_q[N-1]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= {{(N-1){1'b0}}, 1'b1};
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= GRANT;
            grant_q <= sel_d;
            cnt_q   <= CW'(1);
          end
        end
        GRANT: begin
          if (held && (cnt_q != HOLD_LIMIT)) begin
            cnt_q <= cnt_q + CW'(1);
          end else begin
            state_q   <= IDLE;
            grant_q   <= '0;
            cnt_q     <= '0;
            ptr_q     <= ptr_d;
            preempt_q <= held;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant   = grant_q;
  assign ptr     = ptr_q;
  assign busy    = (state_q == GRANT);
  assign preempt = preempt_q;

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Directed bench for rr_ring_arbiter (N=4, MAX_HOLD=8) with hand-computed expectations.
module tb_rr_ring_arbiter;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic [3:0] grant;
  logic [3:0] ptr;
  logic       busy;
  logic       preempt;

  int n_cmp;
  int n_err;

  rr_ring_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .grant   (grant),
    .ptr     (ptr),
    .busy    (busy),
    .preempt (preempt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b0000;
    #2;
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    n_cmp++; if (ptr !== 4'b0001) begin n_err++; $display("FAIL reset_ptr got=%b exp=0001", ptr); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (preempt !== 1'b0) begin n_err++; $display("FAIL reset_preempt got=%b exp=0", preempt); end
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (grant !== 4'b0000 || busy !== 1'b0 || ptr !== 4'b0001) begin
        n_err++; $display("FAIL idle_noreq got grant=%b busy=%b ptr=%b exp 0000/0/0001", grant, busy, ptr);
      end
    end
  endtask

  task automatic test_single_pulse();
    req = 4'b0001;
    step();
    req = 4'b0000;
    n_cmp++; if (grant !== 4'b0001 || busy !== 1'b1) begin
      n_err++; $display("FAIL pulse_grant got grant=%b busy=%b exp 0001/1", grant, busy);
    end
    step();
    n_cmp++; if (grant !== 4'b0000 || busy !== 1'b0) begin
      n_err++; $display("FAIL pulse_release got grant=%b busy=%b exp 0000/0", grant, busy);
    end
    n_cmp++; if (ptr !== 4'b0010) begin n_err++; $display("FAIL pulse_ptr got=%b exp=0010", ptr); end
    n_cmp++; if (preempt !== 1'b0) begin n_err++; $display("FAIL pulse_preempt got=%b exp=0", preempt); end
  endtask

  task automatic test_hold_release();
    req = 4'b0100;
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL hold_latency got=%b exp=0000", grant); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (grant !== 4'b0100 || ptr !== 4'b0010) begin
        n_err++; $display("FAIL hold_cycle%0d got grant=%b ptr=%b exp 0100/0010", i, grant, ptr);
      end
    end
    req = 4'b0000;
    step();
    n_cmp++; if (grant !== 4'b0000 || ptr !== 4'b1000) begin
      n_err++; $display("FAIL hold_release got grant=%b ptr=%b exp 0000/1000", grant, ptr);
    end
    n_cmp++; if (preempt !== 1'b0) begin n_err++; $display("FAIL hold_preempt got=%b exp=0", preempt); end
  endtask

  task automatic test_wrap();
    req = 4'b0011;
    step();
    n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL wrap_grant got=%b exp=0001", grant); end
    req = 4'b0000;
    step();
    n_cmp++; if (grant !== 4'b0000 || ptr !== 4'b0010) begin
      n_err++; $display("FAIL wrap_release got grant=%b ptr=%b exp 0000/0010", grant, ptr);
    end
  endtask

  task automatic test_toggle_others();
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp++; if (grant !== 4'b0010 || preempt !== 1'b0) begin
        n_err++; $display("FAIL toggle_hold%0d got grant=%b preempt=%b exp 0010/0", i, grant, preempt);
      end
      req = req ^ 4'b1101;
    end
    step();
    n_cmp++; if (grant !== 4'b0000 || preempt !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL toggle_revoke got grant=%b preempt=%b busy=%b exp 0000/1/0", grant, preempt, busy);
    end
    n_cmp++; if (ptr !== 4'b0100) begin n_err++; $display("FAIL toggle_ptr got=%b exp=0100", ptr); end
    req = 4'b0000;
    step();
    n_cmp++; if (preempt !== 1'b0 || grant !== 4'b0000) begin
      n_err++; $display("FAIL toggle_pulse_width got preempt=%b grant=%b exp 0/0000", preempt, grant);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    int         pulses;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    n_cmp++; if (ptr !== 4'b0001) begin n_err++; $display("FAIL rr_start_ptr got=%b exp=0001", ptr); end
    exp_g  = 4'b0001;
    pulses = 0;
    req    = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 8; k++) begin
        step();
        if (preempt === 1'b1) pulses++;
        n_cmp++; if (grant !== exp_g || busy !== 1'b1) begin
          n_err++; $display("FAIL rr_grant%0d_cyc%0d got grant=%b busy=%b exp %b/1", g, k, grant, busy, exp_g);
        end
      end
      step();
      if (preempt === 1'b1) pulses++;
      exp_g = {exp_g[2:0], exp_g[3]};
      n_cmp++; if (grant !== 4'b0000 || ptr !== exp_g) begin
        n_err++; $display("FAIL rr_gap%0d got grant=%b ptr=%b exp 0000/%b", g, grant, ptr, exp_g);
      end
    end
    req = 4'b0000;
    n_cmp++; if (pulses !== 5) begin n_err++; $display("FAIL rr_preempt_count got=%0d exp=5", pulses); end
    step();
  endtask

  task automatic test_reset_mid_grant();
    // ptr is 0010 after the round-robin run, so 0100 wins.
    req = 4'b0100;
    step();
    n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL midrst_pre got=%b exp=0100", grant); end
    #3;
    reset = 1'b1;
    #1;
    n_cmp++; if (grant !== 4'b0000 || ptr !== 4'b0001 || busy !== 1'b0 || preempt !== 1'b0) begin
      n_err++; $display("FAIL midrst_async got grant=%b ptr=%b busy=%b preempt=%b exp 0000/0001/0/0", grant, ptr, busy, preempt);
    end
    step();
    n_cmp++; if (grant !== 4'b0000 || preempt !== 1'b0) begin
      n_err++; $display("FAIL midrst_hold got grant=%b preempt=%b exp 0000/0", grant, preempt);
    end
    reset = 1'b0;
    step();
    n_cmp++; if (grant !== 4'b0100 || busy !== 1'b1 || preempt !== 1'b0) begin
      n_err++; $display("FAIL midrst_resume got grant=%b busy=%b preempt=%b exp 0100/1/0", grant, busy, preempt);
    end
    req = 4'b0000;
    step();
    n_cmp++; if (grant !== 4'b0000 || ptr !== 4'b1000) begin
      n_err++; $display("FAIL midrst_release got grant=%b ptr=%b exp 0000/1000", grant, ptr);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single_pulse();
    test_hold_release();
    test_wrap();
    test_toggle_others();
    test_round_robin();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
